mux4_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 4:1 keyed output mux between four requesters, each presenting DATA_W-bit data. It picks one requester, captures its data through the mux into an output register, and acknowledges the requester. It then holds the result under a valid/ready handshake until the consumer accepts it. It sits between board inputs (switches/buttons modelled as requesters) and a downstream consumer such as an LED or seven-segment driver.

---
 rtl/mux4_rr_arbiter.sv | 147 ++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//
// Round-robin arbiter that shares one 4:1 mux between four requesters. It
// picks a winner, registers the winner's data word into out_data, pulses that
// requester's ack for one cycle, and holds the word under a valid/ready
// handshake. When the consumer accepts a word and another request is waiting,
// the next word is captured on the same edge, so the output can move one
// word per cycle.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   req[3:0]   level requests, held by each requester until its ack
//   din0..din3 requester data words (DATA_W bits each)
//   ack[3:0]   one-cycle pulse naming the requester whose word was captured
//   out_valid  out_data/out_sel hold a captured word
//   out_ready  consumer accepts the word when out_valid && out_ready
//   out_data   captured word (registered)
//   out_sel    index of the requester that supplied out_data (registered)
//   busy       high while a word is held
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  input  logic [DATA_W-1:0] din2,
  input  logic [DATA_W-1:0] din3,
  output logic [3:0]        ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_sel,
  output logic              busy
);

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [1:0]        out_sel_q, out_sel_d;
  logic [3:0]        ack_q, ack_d;

  logic [3:0]        ereq;
  logic              win_found;
  logic [1:0]        win_idx;
  logic [DATA_W-1:0] mux_data;
  logic              capture;

  // The requester being acked this cycle still has req high (it drops it on
  // the edge that ends the ack cycle), so it is masked out of arbitration.
  assign ereq = req & ~ack_q;

  // Search from ptr upward with 2-bit wrap. The loop runs from the farthest
  // candidate to the nearest so that the nearest requester is assigned last
  // and therefore wins.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (ereq[ptr_q + 2'(k)]) begin
        win_found = 1'b1;
        win_idx   = ptr_q + 2'(k);
      end
    end
  end

  // The shared 4:1 mux, keyed by the winner index.
  always_comb begin
    mux_data = din0;
    unique case (win_idx)
      2'd0: mux_data = din0;
      2'd1: mux_data = din1;
      2'd2: mux_data = din2;
      2'd3: mux_data = din3;
    endcase
  end

  // Next state. A capture happens whenever there is a winner and the output
  // register is free or being emptied on this same edge.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    ack_d      = 4'b0000;
    capture    = 1'b0;

    unique case (state_q)
      IDLE: begin
        capture = win_found;
      end
      FULL: begin
        if (out_ready) begin
          capture = win_found;
          if (!win_found) begin
            state_d = IDLE;
          end
        end
      end
    endcase

    if (capture) begin
      state_d    = FULL;
      ptr_d      = win_idx + 2'd1;
      out_data_d = mux_data;
      out_sel_d  = win_idx;
      ack_d      = 4'b0001 << win_idx;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of block ordering. The reset is
  // asynchronous: a pending word is dropped at once with no ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 2'd0;
      out_data_q <= '0;
      out_sel_q  <= 2'd0;
      ack_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      ack_q      <= ack_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign busy      = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign ack       = ack_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mux4_rr_arbiter
//
// Self-checking bench for mux4_rr_arbiter (DATA_W = 2). A behavioural model
// tracks the held word, the round-robin pointer and the ack pulse, and is
// advanced on every rising edge from the same inputs the DUT sees. Directed
// scenarios pin the documented grant orders with literal expectations, and a
// randomized phase drives requesters that hold req until the end of their
// ack cycle, occasionally withdraw, and face random backpressure.
// ---------------------------------------------------------------------------
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] din [4];
  logic       out_ready = 1'b0;
  logic [3:0] ack;
  logic       out_valid;
  logic [1:0] out_data;
  logic [1:0] out_sel;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic       m_valid;
  logic [1:0] m_data;
  logic [1:0] m_sel;
  int         m_ptr;
  logic [3:0] m_ack;
  logic [3:0] prev_ack;

  logic [3:0] pending;

  mux4_rr_arbiter #(.DATA_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .din0      (din[0]),
    .din1      (din[1]),
    .din2      (din[2]),
    .din3      (din[3]),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid  = 1'b0;
    m_data   = 2'd0;
    m_sel    = 2'd0;
    m_ptr    = 0;
    m_ack    = 4'b0000;
    prev_ack = 4'b0000;
  endtask

  // One rising edge of the arbiter, described by its rules rather than its
  // implementation: mask the acked requester, scan from the pointer, then
  // either hold, capture, or empty.
  task automatic model_edge();
    logic [3:0] ereq;
    int w;
    ereq = req & ~m_ack;
    w = -1;
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (m_ptr + k) % 4;
      if (w < 0 && ereq[idx]) w = idx;
    end
    if (m_valid && !out_ready) begin
      m_ack = 4'b0000;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_sel   = 2'(w);
      m_data  = din[w];
      m_ack   = 4'b0000;
      m_ack[w] = 1'b1;
      m_ptr   = (w + 1) % 4;
    end else begin
      m_valid = 1'b0;
      m_ack   = 4'b0000;
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data",  32'(out_data),  32'(m_data));
    check("out_sel",   32'(out_sel),   32'(m_sel));
    check("ack",       32'(ack),       32'(m_ack));
    check("busy",      32'(busy),      32'(m_valid));
  endtask

  // Advance one clock; outputs are compared 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    prev_ack = m_ack;
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    req       = 4'b0000;
    out_ready = 1'b0;
    rst       = 1'b1;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) din[i] = 2'd0;

    // Reset state.
    do_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ack",   32'(ack),       32'd0);

    // Single request from requester 0.
    din[0] = 2'b10;
    req    = 4'b0001;
    step();
    check("single_valid", 32'(out_valid), 32'd1);
    check("single_data",  32'(out_data),  32'd2);
    check("single_sel",   32'(out_sel),   32'd0);
    check("single_ack",   32'(ack),       32'd1);
    req       = 4'b0000;
    out_ready = 1'b1;
    step();
    check("single_drain", 32'(out_valid), 32'd0);

    // All four request at full throughput; each drops req after its ack cycle.
    do_reset();
    for (int i = 0; i < 4; i++) din[i] = 2'(i);
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_sel",   32'(out_sel),   32'(i));
      check("b2b_data",  32'(out_data),  32'(i));
      if (i > 0) req[i-1] = 1'b0;
    end
    req[3] = 1'b0;
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Backpressure: word from requester 1 must hold while other inputs churn.
    do_reset();
    din[1]    = 2'd3;
    req       = 4'b0010;
    out_ready = 1'b0;
    step();
    check("bp_first_ack", 32'(ack), 32'b0010);
    for (int c = 0; c < 5; c++) begin
      req = 4'($urandom_range(0, 15)) & 4'b1101;
      for (int i = 0; i < 4; i++) din[i] = 2'($urandom_range(0, 3));
      step();
      check("bp_sel",  32'(out_sel),  32'd1);
      check("bp_data", 32'(out_data), 32'd3);
      check("bp_ack",  32'(ack),      32'd0);
    end
    req       = 4'b0100;
    out_ready = 1'b1;
    step();
    check("bp_next_sel", 32'(out_sel), 32'd2);

    // Pointer wrap: pointer now sits at 3, so 3 wins before 0.
    req = 4'b1001;
    step();
    check("wrap_sel3", 32'(out_sel), 32'd3);
    step();
    check("wrap_sel0", 32'(out_sel), 32'd0);
    req = 4'b0000;
    step();
    check("wrap_drain", 32'(out_valid), 32'd0);

    // Starvation: requester 0 always requesting must alternate with 2.
    do_reset();
    req       = 4'b0101;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("fair_sel", 32'(out_sel), (i % 2 == 0) ? 32'd0 : 32'd2);
    end

    // Asynchronous reset between edges while a word is held.
    do_reset();
    din[0]    = 2'd3;
    req       = 4'b0001;
    out_ready = 1'b0;
    step();
    check("mid_pre_valid", 32'(out_valid), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_data",  32'(out_data),  32'd0);
    check("mid_sel",   32'(out_sel),   32'd0);
    check("mid_ack",   32'(ack),       32'd0);
    model_reset();
    #2;
    rst       = 1'b0;
    req       = 4'b0011;
    out_ready = 1'b1;
    step();
    check("mid_restart_sel", 32'(out_sel), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    pending = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      pending |= 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) pending &= 4'($urandom_range(0, 15));
      req = pending;
      for (int i = 0; i < 4; i++) din[i] = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      pending &= ~prev_ack;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
